// File: rtl/dfd_dst_trace_ctrl.sv
// Trace sequencer for the DST XOR compression stage: arms on CSR config, applies the
// start delay, runs continuous/pulse/window capture and forces periodic or loss-driven resync.
module dfd_dst_trace_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cfg_enable,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_WIDTH-1:0] cfg_start_delay,
    input  logic [CNT_WIDTH-1:0] cfg_window_len,
    input  logic [CNT_WIDTH-1:0] cfg_resync_period,
    input  logic                 trig_start,
    input  logic                 trig_stop,
    input  logic                 pkt_lost,
    output logic                 trace_enable,
    output logic                 trace_start,
    output logic                 trace_stop,
    output logic                 trace_pulse,
    output logic                 retain_original_input,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sample_count
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, RUN, DONE} state_t;

    localparam logic [1:0]           MODE_PULSE = 2'd1;
    localparam logic [1:0]           MODE_WIN   = 2'd2;
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] dly_q, dly_d, win_q, win_d, rs_q, rs_d, sample_q, sample_d;
    logic                 enable_q, start_q, start_d, stop_q, stop_d, pulse_q, pulse_d;
    logic                 retain_q, retain_d, busy_q, done_q;
    logic                 mode_valid, resync_due, start_run;
    logic [CNT_WIDTH-1:0] win_len;

    assign mode_valid = cfg_enable && (cfg_mode != 2'd3);
    assign win_len    = (cfg_window_len == '0) ? ONE : cfg_window_len;
    // Counters hold "cycles since reference + 1", so reaching the period means expiry next cycle.
    assign resync_due = (cfg_resync_period != '0) && (rs_q >= cfg_resync_period);

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        win_d     = win_q;
        rs_d      = rs_q;
        sample_d  = sample_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        pulse_d   = 1'b0;
        retain_d  = 1'b0;
        start_run = 1'b0;
        if (!mode_valid) begin
            state_d  = IDLE;
            sample_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = ARMED;
                    sample_d = '0;
                    dly_d    = '0;
                    win_d    = '0;
                    rs_d     = '0;
                end
                ARMED: begin
                    retain_d = pkt_lost;
                    if (trig_start) begin
                        if (cfg_mode == MODE_PULSE) begin
                            pulse_d  = 1'b1;
                            sample_d = sat_inc(sample_q);
                        end else if (cfg_start_delay == '0) begin
                            start_run = 1'b1;
                        end else begin
                            state_d = DELAY;
                            dly_d   = ONE;
                        end
                    end
                end
                DELAY: begin
                    retain_d = pkt_lost;
                    if (trig_stop)                   state_d   = DONE;
                    else if (dly_q >= cfg_start_delay) start_run = 1'b1;
                    else                             dly_d     = sat_inc(dly_q);
                end
                RUN: begin
                    if (pkt_lost || resync_due) begin
                        retain_d = 1'b1;
                        rs_d     = ONE;
                    end else begin
                        rs_d = sat_inc(rs_q);
                    end
                    win_d = sat_inc(win_q);
                    // The trace_stop cycle is the last RUN cycle; it also counts as a sample.
                    if (stop_q) begin
                        state_d = DONE;
                    end else begin
                        sample_d = sat_inc(sample_q);
                        stop_d   = trig_stop || ((cfg_mode == MODE_WIN) && (win_q >= win_len));
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
            if (start_run) begin
                state_d  = RUN;
                start_d  = 1'b1;
                sample_d = sat_inc(sample_q);
                win_d    = ONE;
                rs_d     = ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dly_q    <= '0;
            win_q    <= '0;
            rs_q     <= '0;
            sample_q <= '0;
            enable_q <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            pulse_q  <= 1'b0;
            retain_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            win_q    <= win_d;
            rs_q     <= rs_d;
            sample_q <= sample_d;
            enable_q <= (state_d != IDLE);
            start_q  <= start_d;
            stop_q   <= stop_d;
            pulse_q  <= pulse_d;
            retain_q <= retain_d;
            busy_q   <= (state_d == DELAY) || (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    assign trace_enable          = enable_q;
    assign trace_start           = start_q;
    assign trace_stop            = stop_q;
    assign trace_pulse           = pulse_q;
    assign retain_original_input = retain_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign sample_count          = sample_q;

endmodule

// File: doc/dfd_dst_trace_ctrl.md
# dfd_dst_trace_ctrl

Trace sequencer that drives the control inputs of the DST XOR compression stage: `trace_enable`, `trace_start`, `trace_stop`, `trace_pulse` and `retain_original_input`. It arms on software configuration and applies a programmable start delay. It supports continuous, pulse and fixed-window capture. It forces full-packet resynchronisation periodically and on packetizer loss. It sits between the DST CSR block and trigger logic on one side and the compression stage on the other.

## Interface
Parameters:
- CNT_WIDTH, 16, width of all delay, window, period and sample counters

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- cfg_enable  in  1  arms the sequencer; 0 returns it to IDLE
- cfg_mode  in  2  capture mode: 0 continuous, 1 pulse, 2 window, 3 reserved (behaves as cfg_enable=0)
- cfg_start_delay  in  CNT_WIDTH  cycles from trigger to trace_start (continuous and window modes)
- cfg_window_len  in  CNT_WIDTH  window length in cycles; 0 is treated as 1
- cfg_resync_period  in  CNT_WIDTH  forced-resync period in RUN; 0 disables it
- trig_start  in  1  start trigger (a pulse request in pulse mode)
- trig_stop  in  1  stop trigger
- pkt_lost  in  1  packetizer dropped a packet
- trace_enable  out  1  to compressor
- trace_start  out  1  to compressor, one-cycle pulse
- trace_stop  out  1  to compressor, one-cycle pulse
- trace_pulse  out  1  to compressor, one-cycle pulse
- retain_original_input  out  1  to compressor, one-cycle pulse
- busy  out  1  state is DELAY or RUN
- done  out  1  state is DONE
- sample_count  out  CNT_WIDTH  captures in the current arming; saturates

## Operation
- All outputs are registered. Reset value of every output is 0, and state resets to IDLE.
- States: IDLE, ARMED, DELAY, RUN, DONE.
- Valid-mode condition: cfg_enable=1 and cfg_mode!=3.
- Valid-mode deassertion: from any state, the next state is IDLE. All outputs go to 0 the next cycle. No trace_stop is issued, because trace_enable=0 terminates capture downstream.
- IDLE -> ARMED when the valid-mode condition holds. Entering ARMED clears sample_count and all internal counters.
- trace_enable=1 in ARMED, DELAY, RUN and DONE.
- ARMED, pulse mode:
  - Each cycle with trig_start=1 asserts trace_pulse the next cycle; state stays ARMED.
  - sample_count increments by 1 per pulse.
  - cfg_start_delay and trig_stop are ignored.
- ARMED, continuous or window mode, on trig_start:
  - If cfg_start_delay=0: go to RUN and assert trace_start the next cycle.
  - Otherwise: go to DELAY.
  - trig_stop in ARMED is ignored, including when it coincides with trig_start.
- DELAY:
  - Counts cycles; trace_start asserts exactly cfg_start_delay+1 cycles after the trig_start cycle, and the state enters RUN.
  - trig_stop in DELAY goes to DONE with no trace_start and no trace_stop.
- RUN:
  - sample_count increments every cycle from the trace_start cycle through the trace_stop cycle inclusive.
  - Continuous mode: trig_stop in cycle M asserts trace_stop at M+1, then the state goes to DONE.
  - Window mode: with trace_start at cycle S, trace_stop asserts at S+max(cfg_window_len,1). An earlier trig_stop terminates the window as in continuous mode.
  - If trig_stop and window expiry coincide, exactly one trace_stop is issued.
- DONE: holds, with done=1, until the valid-mode condition drops. Re-arming requires cfg_enable to toggle.
- Resync counter:
  - Active only in RUN, and cleared at trace_start.
  - When cfg_resync_period!=0 and the counter reaches cfg_resync_period, retain_original_input pulses for 1 cycle and the counter clears.
- Packet loss:
  - pkt_lost in ARMED, DELAY or RUN asserts retain_original_input the next cycle and clears the resync counter.
  - If pkt_lost and resync expiry coincide, only one pulse is issued.
  - pkt_lost is ignored in IDLE and DONE.
- Counters saturate at all-ones; they never wrap.
- Configuration changes while busy=1 are sampled live; this is undefined behaviour for software.

## Timing
- Trigger to trace_start latency is cfg_start_delay+1 cycles.
- Trigger to trace_pulse latency is 1 cycle.
- trig_stop to trace_stop latency is 1 cycle.
- pkt_lost to retain_original_input latency is 1 cycle.
- trace_start, trace_stop and trace_pulse are never asserted in the same cycle.
- Back-to-back trig_start in pulse mode produces back-to-back trace_pulse cycles.
- Synchronous reset mid-RUN: the next cycle shows all outputs 0 and state IDLE.

## Test plan
- Continuous mode, delay 0: trig_start at cycle 10, trig_stop at 20 -> trace_start@11, trace_stop@21, done@22, sample_count=11.
- Window mode, delay 3, window 5: trig_start@10 -> trace_start@14, trace_stop@19, sample_count=6; repeat with window 0 -> trace_stop@15.
- Pulse mode: trig_start at 5, 6 and 9 -> trace_pulse at 6, 7 and 10, sample_count=3, state remains ARMED; a trig_stop@12 has no effect.
- Resync period 4 in continuous mode, with trace_start@11 -> retain_original_input at 15, 19, ...; pkt_lost@16 -> pulse@17, next periodic pulse@21.
- trig_stop during DELAY -> DONE with no trace_start or trace_stop; trig_start+trig_stop together in ARMED -> normal start.
- cfg_enable dropped mid-RUN, and reset_n low mid-RUN -> all outputs 0 next cycle, state IDLE, no trace_stop.
